// File: rtl/core_writeback_stage.sv
// Final pipeline stage: drives the register-file write port from execute results
// and from load responses. Load responses are byte/half extracted and
// sign/zero-extended. Misaligned, illegal-size and timed-out loads raise a
// one-cycle error pulse.
module core_writeback_stage #(
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_rd_use,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_mem_op,
  input  logic [2:0]  ex_load_size,
  input  logic [1:0]  ex_addr_lo,
  input  logic [31:0] ex_result,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_data,
  output logic        pend_valid,
  output logic [4:0]  pend_addr,
  output logic        load_err
);

  localparam int DATA_WIDTH = 32;
  localparam int CNT_W      = $clog2(LOAD_TIMEOUT + 1);

  localparam logic [2:0] SZ_LB  = 3'b000;
  localparam logic [2:0] SZ_LH  = 3'b001;
  localparam logic [2:0] SZ_LW  = 3'b010;
  localparam logic [2:0] SZ_LBU = 3'b100;
  localparam logic [2:0] SZ_LHU = 3'b101;

  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [4:0]             ld_rd_q;
  logic [2:0]             ld_size_q;
  logic [1:0]             ld_off_q;

  logic                   transfer;
  logic                   is_load;
  logic                   load_legal;
  logic                   timeout;
  logic [DATA_WIDTH-1:0]  load_value;

  logic                   rf_we_d, pend_valid_d, load_err_d;
  logic [4:0]             rf_addr_d, pend_addr_d;
  logic [DATA_WIDTH-1:0]  rf_data_d;

  assign ex_ready = (state_q == IDLE);
  assign transfer = ex_valid & ex_ready;
  assign is_load  = ex_mem_op & ex_rd_use;
  // The last WAIT cycle is the one where the counter reads LOAD_TIMEOUT-1;
  // a response in that same cycle takes priority over the abort.
  assign timeout  = (state_q == WAIT_LOAD) && !mem_rvalid &&
                    (cnt_q == CNT_W'(LOAD_TIMEOUT - 1));

  // Size/alignment legality of the incoming load.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    load_legal = 1'b0;
    case (ex_load_size)
      SZ_LB, SZ_LBU: load_legal = 1'b1;
      SZ_LH, SZ_LHU: load_legal = ~ex_addr_lo[0];
      SZ_LW:         load_legal = (ex_addr_lo == 2'b00);
      default:       load_legal = 1'b0;
    endcase
  end

  // State, timeout counter and captured load descriptor.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ld_rd_q   <= '0;
      ld_size_q <= '0;
      ld_off_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && transfer && is_load && load_legal) begin
        ld_rd_q   <= ex_rd_addr;
        ld_size_q <= ex_load_size;
        ld_off_q  <= ex_addr_lo;
      end
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (transfer && is_load && load_legal) begin
          state_d = WAIT_LOAD;
          cnt_d   = '0;
        end
      end
      WAIT_LOAD: begin
        if (mem_rvalid || timeout) state_d = IDLE;
        else                       cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Extract and extend the load response according to the captured size/offset.
  always_comb begin
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    byte_sel   = mem_rdata[{ld_off_q, 3'b000} +: 8];
    half_sel   = mem_rdata[{ld_off_q[1], 4'b0000} +: 16];
    load_value = mem_rdata;
    case (ld_size_q)
      SZ_LB:   load_value = {{24{byte_sel[7]}}, byte_sel};
      SZ_LBU:  load_value = {24'h0, byte_sel};
      SZ_LH:   load_value = {{16{half_sel[15]}}, half_sel};
      SZ_LHU:  load_value = {16'h0, half_sel};
      default: load_value = mem_rdata;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    rf_we_d      = 1'b0;
    load_err_d   = 1'b0;
    rf_addr_d    = rf_addr;
    rf_data_d    = rf_data;
    pend_valid_d = pend_valid;
    pend_addr_d  = pend_addr;
    case (state_q)
      IDLE: begin
        if (transfer && !ex_mem_op) begin
          if (ex_rd_use && ex_rd_addr != 5'd0) begin
            rf_we_d   = 1'b1;
            rf_addr_d = ex_rd_addr;
            rf_data_d = ex_result;
          end
        end else if (transfer && is_load) begin
          if (load_legal) begin
            pend_valid_d = 1'b1;
            pend_addr_d  = ex_rd_addr;
          end else begin
            load_err_d = 1'b1;
          end
        end
      end
      WAIT_LOAD: begin
        if (mem_rvalid) begin
          rf_we_d      = (ld_rd_q != 5'd0);
          rf_addr_d    = ld_rd_q;
          rf_data_d    = load_value;
          pend_valid_d = 1'b0;
        end else if (timeout) begin
          load_err_d   = 1'b1;
          pend_valid_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we      <= 1'b0;
      rf_addr    <= '0;
      rf_data    <= '0;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      load_err   <= 1'b0;
    end else begin
      rf_we      <= rf_we_d;
      rf_addr    <= rf_addr_d;
      rf_data    <= rf_data_d;
      pend_valid <= pend_valid_d;
      pend_addr  <= pend_addr_d;
      load_err   <= load_err_d;
    end
  end

endmodule

// File: tb/tb_core_writeback_stage.sv
// Directed testbench for core_writeback_stage (LOAD_TIMEOUT = 4).
// Inputs change 1 ns after a rising edge; outputs are checked at that point,
// so the values seen belong to the cycle just started.
module tb_core_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready, ex_rd_use, ex_mem_op;
  logic [4:0]  ex_rd_addr;
  logic [2:0]  ex_load_size;
  logic [1:0]  ex_addr_lo;
  logic [31:0] ex_result;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_we, pend_valid, load_err;
  logic [4:0]  rf_addr, pend_addr;
  logic [31:0] rf_data;

  int n_checks = 0;
  int n_fail   = 0;

  core_writeback_stage #(.LOAD_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd_use(ex_rd_use),
    .ex_rd_addr(ex_rd_addr), .ex_mem_op(ex_mem_op), .ex_load_size(ex_load_size),
    .ex_addr_lo(ex_addr_lo), .ex_result(ex_result),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
    .pend_valid(pend_valid), .pend_addr(pend_addr), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid     = 1'b0;
    ex_rd_use    = 1'b0;
    ex_rd_addr   = 5'd0;
    ex_mem_op    = 1'b0;
    ex_load_size = 3'b000;
    ex_addr_lo   = 2'b00;
    ex_result    = 32'h0;
    mem_rvalid   = 1'b0;
    mem_rdata    = 32'h0;
  endtask

  task automatic drive_alu(input logic use_rd, input logic [4:0] rd, input logic [31:0] res);
    idle_inputs();
    ex_valid = 1'b1; ex_rd_use = use_rd; ex_rd_addr = rd; ex_result = res;
  endtask

  task automatic drive_load(input logic [2:0] size, input logic [1:0] off, input logic [4:0] rd);
    idle_inputs();
    ex_valid = 1'b1; ex_mem_op = 1'b1; ex_rd_use = 1'b1;
    ex_load_size = size; ex_addr_lo = off; ex_rd_addr = rd;
  endtask

  // Load accepted in cycle 0, response in cycle 3, write expected in cycle 4.
  task automatic load_case(input string tag, input logic [2:0] size, input logic [1:0] off,
                           input logic [4:0] rd, input logic [31:0] rdata, input logic [31:0] exp);
    drive_load(size, off, rd);
    check({tag, " ready_c0"}, ex_ready, 1);
    step(); idle_inputs();
    check({tag, " ready_wait"}, ex_ready, 0);
    check({tag, " pend_valid"}, pend_valid, 1);
    check({tag, " pend_addr"}, pend_addr, rd);
    step(); step();
    check({tag, " still_pend"}, pend_valid, 1);
    mem_rvalid = 1'b1; mem_rdata = rdata;
    step(); idle_inputs();
    check({tag, " we"}, rf_we, 1);
    check({tag, " addr"}, rf_addr, rd);
    check({tag, " data"}, rf_data, exp);
    check({tag, " pend_clr"}, pend_valid, 0);
    check({tag, " ready_back"}, ex_ready, 1);
    step();
    check({tag, " we_drop"}, rf_we, 0);
  endtask

  task automatic bad_load(input string tag, input logic [2:0] size, input logic [1:0] off);
    drive_load(size, off, 5'd7);
    step(); idle_inputs();
    check({tag, " err"}, load_err, 1);
    check({tag, " we"}, rf_we, 0);
    check({tag, " ready"}, ex_ready, 1);
    check({tag, " pend"}, pend_valid, 0);
    step();
    check({tag, " err_drop"}, load_err, 0);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    step(); step();
    check("rst rf_we", rf_we, 0);
    check("rst rf_addr", rf_addr, 0);
    check("rst rf_data", rf_data, 0);
    check("rst pend_valid", pend_valid, 0);
    check("rst load_err", load_err, 0);
    rst = 1'b0;
    check("rst ex_ready", ex_ready, 1);

    // 1: back-to-back ALU writes
    drive_alu(1'b1, 5'd5, 32'hDEADBEEF);
    step();
    check("alu1 we", rf_we, 1);
    check("alu1 addr", rf_addr, 5);
    check("alu1 data", rf_data, 32'hDEADBEEF);
    drive_alu(1'b1, 5'd6, 32'h1);
    step(); idle_inputs();
    check("alu2 we", rf_we, 1);
    check("alu2 addr", rf_addr, 6);
    check("alu2 data", rf_data, 32'h1);
    step();
    check("alu idle we", rf_we, 0);

    // 2: x0 destination and a store
    drive_alu(1'b1, 5'd0, 32'h1234);
    step();
    check("x0 we", rf_we, 0);
    check("x0 ready", ex_ready, 1);
    idle_inputs(); ex_valid = 1'b1; ex_mem_op = 1'b1; ex_rd_use = 1'b0;
    step(); idle_inputs();
    check("store we", rf_we, 0);
    check("store ready", ex_ready, 1);
    check("store pend", pend_valid, 0);
    check("hold data", rf_data, 32'h1);

    // 3: loads with extraction
    load_case("lb",  3'b000, 2'd2, 5'd9,  32'h0080FF00, 32'hFFFFFF80);
    load_case("lbu", 3'b100, 2'd2, 5'd10, 32'h0080FF00, 32'h00000080);
    load_case("lhu", 3'b101, 2'd2, 5'd11, 32'h80011234, 32'h00008001);
    load_case("lh",  3'b001, 2'd2, 5'd12, 32'h80011234, 32'hFFFF8001);
    load_case("lb0", 3'b000, 2'd0, 5'd13, 32'h0080FF7F, 32'h0000007F);
    load_case("lw",  3'b010, 2'd0, 5'd14, 32'hCAFEF00D, 32'hCAFEF00D);

    // 4: misaligned and illegal loads
    bad_load("lh_off1", 3'b001, 2'd1);
    bad_load("sz011",   3'b011, 2'd0);
    bad_load("lw_off2", 3'b010, 2'd2);
    bad_load("sz110",   3'b110, 2'd0);

    // 5a: timeout, late response ignored
    drive_load(3'b010, 2'd0, 5'd15);
    step(); idle_inputs();                 // cycle 1
    step(); step(); step();                // cycle 4
    check("to c4 err", load_err, 0);
    check("to c4 ready", ex_ready, 0);
    step();                                // cycle 5
    check("to err", load_err, 1);
    check("to we", rf_we, 0);
    check("to ready", ex_ready, 1);
    check("to pend", pend_valid, 0);
    step();                                // cycle 6
    check("to err_drop", load_err, 0);
    mem_rvalid = 1'b1; mem_rdata = 32'h55555555;
    step(); idle_inputs();                 // cycle 7
    check("late we", rf_we, 0);
    check("late data", rf_data, 32'hCAFEF00D);

    // 5b: response in the last WAIT cycle wins
    drive_load(3'b010, 2'd0, 5'd16);
    step(); idle_inputs();                 // cycle 1
    step(); step(); step();                // cycle 4
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    step(); idle_inputs();                 // cycle 5
    check("edge we", rf_we, 1);
    check("edge err", load_err, 0);
    check("edge data", rf_data, 32'h12345678);
    check("edge addr", rf_addr, 16);

    // 6: reset during WAIT_LOAD
    drive_load(3'b000, 2'd0, 5'd17);
    step(); idle_inputs();
    check("r6 pend", pend_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("r6 ready", ex_ready, 1);
    check("r6 pend", pend_valid, 0);
    check("r6 pend_addr", pend_addr, 0);
    check("r6 rf_addr", rf_addr, 0);
    check("r6 rf_data", rf_data, 0);
    check("r6 we", rf_we, 0);
    check("r6 err", load_err, 0);
    mem_rvalid = 1'b1; mem_rdata = 32'h000000AA;
    step(); idle_inputs();
    check("r6 post we", rf_we, 0);
    check("r6 post data", rf_data, 0);
    check("r6 post err", load_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
